sid_mac_clip: RTL and testbench



---
 rtl/sid_mac_clip.sv | 95 +++++++++
 tb/tb_sid_mac_clip.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sid_mac_clip.sv
`default_nettype none
// ============================================================================
// Module      : sid_mac_clip
// Description : Shared arithmetic datapath for the SID state-variable filter.
//               One registered 17x16 fractional multiplier, time-shared by the
//               filter sequencer for its cutoff and resonance products. Three
//               combinational saturating clippers reduce the 17-bit low/band/
//               high integrator states to 16-bit audio samples.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1        system clock, rising edge
//   rst      in   1        synchronous active-high reset (multiplier only)
//   iSignal  in   17 s     multiplier signal operand (band or high state)
//   iCoef    in   16 u     multiplier coefficient, Q0.16 fraction
//   oOut     out  16 s     registered (iSignal * iCoef) >> 16, 1-cycle latency
//   iLow     in   17 s     low-pass integrator state
//   iBand    in   17 s     band-pass integrator state
//   iHigh    in   17 s     high-pass state
//   oLP      out  16 s     iLow saturated to 16 bits
//   oBP      out  16 s     iBand saturated to 16 bits
//   oHP      out  16 s     iHigh saturated to 16 bits
// ============================================================================
module sid_mac_clip (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [16:0] iSignal,
    input  logic        [15:0] iCoef,
    output logic signed [15:0] oOut,
    input  logic signed [16:0] iLow,
    input  logic signed [16:0] iBand,
    input  logic signed [16:0] iHigh,
    output logic signed [15:0] oLP,
    output logic signed [15:0] oBP,
    output logic signed [15:0] oHP
);

    localparam int C_NUM_CLIP = 3;

    // ------------------------------------------------------------------------
    // Multiplier
    // ------------------------------------------------------------------------
    // Both operands are widened to the full 34-bit product width before the
    // multiply so the product is exact: the signal is sign-extended and the
    // coefficient zero-extended (it is an unsigned fraction).
    logic signed [33:0] w_sig_ext;
    logic signed [33:0] w_coef_ext;
    logic signed [33:0] w_product;
    logic signed [15:0] r_out;

    assign w_sig_ext  = {{17{iSignal[16]}}, iSignal};
    assign w_coef_ext = {18'd0, iCoef};
    assign w_product  = w_sig_ext * w_coef_ext;

    // Arithmetic shift floors toward -inf; the 16-bit cast then keeps
    // product bits [31:16] and lets out-of-range results wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= 16'(w_product >>> 16);
        end
    end

    assign oOut = r_out;

    // ------------------------------------------------------------------------
    // Saturating clippers (purely combinational, independent of clk/rst)
    // ------------------------------------------------------------------------
    logic [16:0] w_clip_in  [C_NUM_CLIP];
    logic [15:0] w_clip_out [C_NUM_CLIP];

    assign w_clip_in[0] = iLow;
    assign w_clip_in[1] = iBand;
    assign w_clip_in[2] = iHigh;

    generate
        for (genvar gi = 0; gi < C_NUM_CLIP; gi++) begin : g_clip
            // A 17-bit value fits in 16 bits exactly when its top two bits
            // agree. When they differ, bit 16 gives the direction of overflow.
            always_comb begin
                w_clip_out[gi] = w_clip_in[gi][15:0];
                if (w_clip_in[gi][16] != w_clip_in[gi][15]) begin
                    w_clip_out[gi] = w_clip_in[gi][16] ? 16'h8000 : 16'h7FFF;
                end
            end
        end
    endgenerate

    assign oLP = w_clip_out[0];
    assign oBP = w_clip_out[1];
    assign oHP = w_clip_out[2];

endmodule
`default_nettype wire

// File: tb/tb_sid_mac_clip.sv
`default_nettype none
// ============================================================================
// Module      : tb_sid_mac_clip
// Description : Self-checking bench for sid_mac_clip. Directed multiplier,
//               reset and clipper cases plus randomized back-to-back operands,
//               all checked against arithmetic reference models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sid_mac_clip;

    logic               clk;
    logic               rst;
    logic signed [16:0] iSignal;
    logic        [15:0] iCoef;
    logic signed [15:0] oOut;
    logic signed [16:0] iLow;
    logic signed [16:0] iBand;
    logic signed [16:0] iHigh;
    logic signed [15:0] oLP;
    logic signed [15:0] oBP;
    logic signed [15:0] oHP;

    int n_total;
    int n_bad;

    sid_mac_clip u_dut (
        .clk     (clk),
        .rst     (rst),
        .iSignal (iSignal),
        .iCoef   (iCoef),
        .oOut    (oOut),
        .iLow    (iLow),
        .iBand   (iBand),
        .iHigh   (iHigh),
        .oLP     (oLP),
        .oBP     (oBP),
        .oHP     (oHP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: floor(s*c / 65536), then wrap to 16 bits.
    function automatic logic [15:0] mul_ref(input int s, input int c);
        longint p;
        longint q;
        p = longint'(s) * longint'(c);
        q = p / 65536;
        if (p < 0 && (p % 65536) != 0) q = q - 1;
        return 16'(q);
    endfunction

    // Reference: saturate to the signed 16-bit range.
    function automatic logic [15:0] clip_ref(input int v);
        if (v > 32767)  return 16'(32767);
        if (v < -32768) return 16'(-32768);
        return 16'(v);
    endfunction

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
                     tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mul_case(input string tag, input int s, input int c);
        iSignal = 17'(s);
        iCoef   = 16'(c);
        step();
        chk(tag, oOut, mul_ref(s, c));
    endtask

    task automatic clip_case(input string tag, input int v);
        iLow  = 17'(v);
        iBand = 17'(v);
        iHigh = 17'(v);
        #1;
        chk({tag, "_lp"}, oLP, clip_ref(v));
        chk({tag, "_bp"}, oBP, clip_ref(v));
        chk({tag, "_hp"}, oHP, clip_ref(v));
    endtask

    int clip_vals [7] = '{40000, -40000, 32767, -32768, -65536, 65535, 0};

    initial begin
        int s;
        int c;
        int a;
        int b;
        int h;
        logic [15:0] prev_exp;
        logic [15:0] cur_exp;

        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        iSignal = 17'sd16384;
        iCoef   = 16'h8000;
        iLow    = '0;
        iBand   = '0;
        iHigh   = '0;

        // Reset state: non-zero operands must still give 0.
        step();
        step();
        chk("reset_value", oOut, 16'd0);
        rst = 1'b0;
        step();
        chk("first_after_reset", oOut, 16'd8192);

        // Directed multiplier cases.
        mul_case("nominal_pos", 16384, 32'h8000);
        chk("nominal_pos_const", oOut, 16'd8192);
        mul_case("nominal_neg", -16384, 32'h8000);
        chk("nominal_neg_const", oOut, 16'hE000);
        mul_case("floor_m1", -1, 1);
        chk("floor_m1_const", oOut, 16'hFFFF);
        mul_case("small_pos", 1, 32'hFFFF);
        chk("small_pos_const", oOut, 16'h0000);
        mul_case("coef_zero_a", -65536, 0);
        mul_case("coef_zero_b", 12345, 0);
        mul_case("wrap", 65535, 32'hFFFF);
        chk("wrap_const", oOut, 16'hFFFE);
        mul_case("most_neg", -65536, 32'hFFFF);

        // Mid-stream reset.
        iSignal = 17'sd16384;
        iCoef   = 16'h8000;
        step();
        chk("pre_reset", oOut, 16'd8192);
        rst = 1'b1;
        step();
        chk("mid_reset", oOut, 16'd0);
        rst = 1'b0;
        step();
        chk("post_reset", oOut, 16'd8192);

        // Randomized back-to-back operands: before each edge the output still
        // shows the previous product; after the edge it shows the new one.
        prev_exp = 16'd8192;
        for (int i = 0; i < 300; i++) begin
            s = int'($signed(17'($urandom)));
            c = int'($urandom_range(0, 65535));
            if (i % 10 == 0) s = (i % 20 == 0) ? 65535 : -65536;
            iSignal = 17'(s);
            iCoef   = 16'(c);
            cur_exp = mul_ref(s, c);
            #1;
            chk("rand_hold", oOut, prev_exp);
            step();
            chk("rand_prod", oOut, cur_exp);
            prev_exp = cur_exp;
        end

        // Clipper bounds on all three channels.
        foreach (clip_vals[k]) begin
            clip_case($sformatf("clip_%0d", clip_vals[k]), clip_vals[k]);
        end

        // Clipper independence and insensitivity to reset.
        for (int i = 0; i < 20; i++) begin
            a = int'($signed(17'($urandom)));
            b = int'($signed(17'($urandom)));
            h = int'($signed(17'($urandom_range(0, 65535)))) - 32768;
            iLow  = 17'(a);
            iBand = 17'(b);
            iHigh = 17'(h);
            #1;
            chk("indep_lp", oLP, clip_ref(a));
            chk("indep_bp", oBP, clip_ref(b));
            chk("indep_hp", oHP, clip_ref(h));
            rst = 1'b1;
            step();
            chk("rst_lp", oLP, clip_ref(a));
            chk("rst_bp", oBP, clip_ref(b));
            chk("rst_hp", oHP, clip_ref(h));
            rst = 1'b0;
            step();
            chk("unrst_hp", oHP, clip_ref(h));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
